// File: rtl/dm_arbiter.sv
// Two-port arbiter/sequencer for the shared single-port data memory.
// Define DM_ARB_FIXED_PRIO_EN for fixed port-0 priority on ties.
module dm_arbiter #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          m0_req,
  input  logic          m1_req,
  input  logic          m0_we,
  input  logic          m1_we,
  input  logic [AW-1:0] m0_addr,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m0_wdata,
  input  logic [DW-1:0] m1_wdata,
  input  logic [31:0]   m0_pc,
  input  logic [31:0]   m1_pc,
  output logic          m0_ack,
  output logic          m1_ack,
  output logic [DW-1:0] m0_rdata,
  output logic [DW-1:0] m1_rdata,
  output logic [AW-1:0] mem_A,
  output logic [DW-1:0] mem_WData,
  output logic          mem_MemRead,
  output logic          mem_MemWrite,
  output logic [31:0]   mem_PC0,
  input  logic [DW-1:0] mem_RD
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic          cur;
  logic          last_grant;
  logic          grant;
  logic          win;
  logic          h_we;
  logic [AW-1:0] h_addr;
  logic [DW-1:0] h_wdata;
  logic [31:0]   h_pc;

  always_comb begin
    grant = m0_req | m1_req;
`ifdef DM_ARB_FIXED_PRIO_EN
    win = ~m0_req;
`else
    // on a tie the port not granted last time wins
    win = (m0_req & m1_req) ? ~last_grant : m1_req;
`endif
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (grant) state_nx = ACCESS;
      ACCESS:  state_nx = RESP;
      RESP:    state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cur        <= 1'b0;
      last_grant <= 1'b1;
      h_we       <= 1'b0;
      h_addr     <= '0;
      h_wdata    <= '0;
      h_pc       <= '0;
      m0_rdata   <= '0;
      m1_rdata   <= '0;
    end else begin
      state <= state_nx;
      if (state == IDLE && grant) begin
        cur        <= win;
        last_grant <= win;
        h_we       <= win ? m1_we    : m0_we;
        h_addr     <= win ? m1_addr  : m0_addr;
        h_wdata    <= win ? m1_wdata : m0_wdata;
        h_pc       <= win ? m1_pc    : m0_pc;
      end
      if (state == ACCESS && !h_we) begin
        if (cur) m1_rdata <= mem_RD;
        else     m0_rdata <= mem_RD;
      end
    end
  end

  assign mem_A     = h_addr;
  assign mem_WData = h_wdata;
  assign mem_PC0   = h_pc;

  assign mem_MemRead  = (state == ACCESS) & ~h_we;
  // reset gates the strobe so an in-flight write never lands
  assign mem_MemWrite = (state == ACCESS) & h_we & ~reset;

  assign m0_ack = (state == RESP) & ~cur;
  assign m1_ack = (state == RESP) & cur;

endmodule

// File: tb/tb_dm_arbiter.sv
// Directed bench for dm_arbiter with a behavioural 1K-word memory.
// Expectations follow DM_ARB_FIXED_PRIO_EN when defined.
module tb_dm_arbiter;

`ifdef DM_ARB_FIXED_PRIO_EN
  localparam bit FIXED = 1'b1;
`else
  localparam bit FIXED = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        m0_req, m1_req, m0_we, m1_we;
  logic [9:0]  m0_addr, m1_addr;
  logic [31:0] m0_wdata, m1_wdata, m0_pc, m1_pc;
  logic        m0_ack, m1_ack;
  logic [31:0] m0_rdata, m1_rdata;
  logic [9:0]  mem_A;
  logic [31:0] mem_WData, mem_PC0, mem_RD;
  logic        mem_MemRead, mem_MemWrite;
  logic        init_mem;
  logic [31:0] mem [0:1023];

  int n_cmp = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  dm_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req(m0_req), .m1_req(m1_req),
    .m0_we(m0_we), .m1_we(m1_we),
    .m0_addr(m0_addr), .m1_addr(m1_addr),
    .m0_wdata(m0_wdata), .m1_wdata(m1_wdata),
    .m0_pc(m0_pc), .m1_pc(m1_pc),
    .m0_ack(m0_ack), .m1_ack(m1_ack),
    .m0_rdata(m0_rdata), .m1_rdata(m1_rdata),
    .mem_A(mem_A), .mem_WData(mem_WData),
    .mem_MemRead(mem_MemRead),
    .mem_MemWrite(mem_MemWrite),
    .mem_PC0(mem_PC0), .mem_RD(mem_RD)
  );

  assign mem_RD = mem[mem_A];

  always @(posedge clk) begin
    if (init_mem) begin
      for (int i = 0; i < 1024; i++)
        mem[i] <= 32'h1000_0000 + 32'(i);
      mem[5] <= 32'hDEAD_BEEF;
    end else if (mem_MemWrite) begin
      mem[mem_A] <= mem_WData;
    end
  end

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, want %h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        r0, r1, we0, we1;
    logic [9:0]  a0, a1;
    logic [31:0] d0, d1, pc0, pc1;
    int          port;
    logic [31:0] rd;
    logic [9:0]  a;
    logic [31:0] pc;
    logic        wr;
  } vec_t;

  vec_t tv [9];

  task automatic idle_inputs();
    m0_req = 0; m1_req = 0; m0_we = 0; m1_we = 0;
    m0_addr = 0; m1_addr = 0; m0_wdata = 0; m1_wdata = 0;
    m0_pc = 0; m1_pc = 0;
  endtask

  task automatic run_vec(int i);
    vec_t v = tv[i];
    int got = -1, lat = 0, nstb = 0;
    logic both = 0, sw = 0;
    logic [9:0] sa = 0;
    logic [31:0] spc = 0, srd = 0;
    m0_req = v.r0; m1_req = v.r1; m0_we = v.we0; m1_we = v.we1;
    m0_addr = v.a0; m1_addr = v.a1;
    m0_wdata = v.d0; m1_wdata = v.d1;
    m0_pc = v.pc0; m1_pc = v.pc1;
    for (int k = 0; k < 6; k++) begin
      @(posedge clk); @(negedge clk);
      if (mem_MemRead || mem_MemWrite) begin
        nstb++; sa = mem_A; spc = mem_PC0; sw = mem_MemWrite;
      end
      if (m0_ack && m1_ack) both = 1;
      if (m0_ack || m1_ack) begin
        got = m1_ack ? 1 : 0;
        srd = m1_ack ? m1_rdata : m0_rdata;
        lat = k + 1;
        break;
      end
    end
    idle_inputs();
    check($sformatf("v%0d port", i), 32'(got), 32'(v.port));
    check($sformatf("v%0d latency", i), 32'(lat), 32'd2);
    check($sformatf("v%0d strobes", i), 32'(nstb), 32'd1);
    check($sformatf("v%0d addr", i), 32'(sa), 32'(v.a));
    check($sformatf("v%0d pc", i), spc, v.pc);
    check($sformatf("v%0d write", i), 32'(sw), 32'(v.wr));
    check($sformatf("v%0d dual ack", i), 32'(both), 32'd0);
    if (!v.wr) check($sformatf("v%0d rdata", i), srd, v.rd);
    @(negedge clk);
  endtask

  task automatic check_zero(string tag);
    check({tag, " m0_ack"}, 32'(m0_ack), 0);
    check({tag, " m1_ack"}, 32'(m1_ack), 0);
    check({tag, " m0_rdata"}, m0_rdata, 0);
    check({tag, " m1_rdata"}, m1_rdata, 0);
    check({tag, " mem_A"}, 32'(mem_A), 0);
    check({tag, " mem_WData"}, mem_WData, 0);
    check({tag, " mem_PC0"}, mem_PC0, 0);
    check({tag, " MemRead"}, 32'(mem_MemRead), 0);
    check({tag, " MemWrite"}, 32'(mem_MemWrite), 0);
  endtask

  initial begin
    int nack;
    int seq [8];
    logic both;

    tv[0] = '{1,0,0,0, 10'd5,0, 0,0, 32'h100,0,
              0, 32'hDEAD_BEEF, 10'd5, 32'h100, 0};
    tv[1] = '{0,1,0,0, 0,10'd20, 0,0, 0,32'h200,
              1, 32'h1000_0014, 10'd20, 32'h200, 0};
    tv[2] = '{1,1,0,0, 10'd30,10'd31, 0,0, 32'h300,32'h301,
              0, 32'h1000_001E, 10'd30, 32'h300, 0};
    tv[3] = '{1,1,0,0, 10'd40,10'd41, 0,0, 32'h400,32'h401,
              FIXED ? 0 : 1,
              FIXED ? 32'h1000_0028 : 32'h1000_0029,
              FIXED ? 10'd40 : 10'd41,
              FIXED ? 32'h400 : 32'h401, 0};
    tv[4] = '{1,0,1,0, 10'd100,0, 32'hAAAA_5555,0, 32'h500,0,
              0, 0, 10'd100, 32'h500, 1};
    tv[5] = '{1,0,0,0, 10'd100,0, 0,0, 32'h600,0,
              0, 32'hAAAA_5555, 10'd100, 32'h600, 0};
    tv[6] = '{1,1,0,0, 10'h200,10'd2, 0,0, 32'h700,32'h701,
              FIXED ? 0 : 1,
              FIXED ? 32'h1000_0200 : 32'h1000_0002,
              FIXED ? 10'h200 : 10'd2,
              FIXED ? 32'h700 : 32'h701, 0};
    tv[7] = '{0,1,0,1, 0,10'h3FF, 0,32'h1234_5678, 0,32'h3000,
              1, 0, 10'h3FF, 32'h3000, 1};
    tv[8] = '{1,0,0,0, 10'h3FF,0, 0,0, 32'h800,0,
              0, 32'h1234_5678, 10'h3FF, 32'h800, 0};

    idle_inputs();
    reset = 1; init_mem = 1;
    repeat (2) @(negedge clk);
    reset = 0; init_mem = 0;
    check_zero("reset");

    for (int i = 0; i < 9; i++) run_vec(i);

    // continuous contention starting from reset state
    reset = 1; @(negedge clk); reset = 0;
    m0_req = 1; m1_req = 1; m0_addr = 10'd1; m1_addr = 10'd2;
    nack = 0; both = 0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk); @(negedge clk);
      if (m0_ack && m1_ack) both = 1;
      if ((m0_ack || m1_ack) && nack < 8) begin
        seq[nack] = m1_ack ? 1 : 0;
        nack++;
      end
    end
    idle_inputs();
    check("contend acks", 32'(nack), 32'd4);
    check("contend dual", 32'(both), 32'd0);
    for (int j = 0; j < 4; j++)
      if (j < nack)
        check($sformatf("contend grant%0d", j), 32'(seq[j]),
              FIXED ? 32'd0 : 32'(j % 2));
    @(negedge clk);

    // reset during the ACCESS cycle of a write
    m0_req = 1; m0_we = 1; m0_addr = 10'd50;
    m0_wdata = 32'h55AA_55AA; m0_pc = 32'h44;
    @(posedge clk); @(negedge clk);
    check("rst pending write", 32'(mem_MemWrite), 1);
    reset = 1; idle_inputs();
    #1 check("rst write gated", 32'(mem_MemWrite), 0);
    @(negedge clk);
    reset = 0;
    check_zero("rst mid");
    nack = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); @(negedge clk);
      if (m0_ack || m1_ack) nack++;
    end
    check("rst no ack", 32'(nack), 0);
    check("rst mem untouched", mem[50], 32'h1000_0032);

    // request inputs change after capture
    m0_req = 1; m0_we = 0; m0_addr = 10'd7; m0_pc = 32'h77;
    @(posedge clk); @(negedge clk);
    m0_addr = 10'd9; m0_we = 1; m0_wdata = 32'hFFFF_FFFF;
    #1;
    check("chg addr", 32'(mem_A), 32'd7);
    check("chg read", 32'(mem_MemRead), 1);
    check("chg no write", 32'(mem_MemWrite), 0);
    @(posedge clk); @(negedge clk);
    check("chg ack", 32'(m0_ack), 1);
    check("chg rdata", m0_rdata, 32'h1000_0007);
    idle_inputs();
    @(negedge clk);
    check("chg mem9", mem[9], 32'h1000_0009);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_fail);
    $finish;
  end

endmodule
